// File: rtl/ld_pkg.sv
// Shared definitions for the load alignment unit: load opcode encoding,
// bus transfer size codes, FSM state type, and alignment/size helpers.
package ld_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLbu = 3'd1,
        OpLh  = 3'd2,
        OpLhu = 3'd3,
        OpLw  = 3'd4,
        OpLwl = 3'd5,
        OpLwr = 3'd6
    } ld_op_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } ld_state_e;

    // LWL/LWR are unaligned by definition and never fault.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] byte_off);
        logic bad;
        bad = 1'b0;
        case (op)
            OpLh, OpLhu: bad = byte_off[0];
            OpLw:        bad = (byte_off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] size_of(input logic [2:0] op);
        logic [1:0] sz;
        case (op)
            OpLb, OpLbu: sz = SizeByte;
            OpLh, OpLhu: sz = SizeHalf;
            default:     sz = SizeWord;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_extractor.sv
// Combinational lane selection, sign/zero extension and LWL/LWR merge.
// Ports:
//   op        load opcode (ld_pkg encoding)
//   byte_addr low two bits of the effective address
//   rdata     word returned by the data bus
//   rt_old    current destination value, merged by LWL/LWR
//   result    value to write back
module load_extractor
    import ld_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  byte_addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;

    always_comb begin
        byte_sel = rdata[{byte_addr, 3'b000} +: 8];
        half_sel = rdata[{byte_addr[1], 4'b0000} +: 16];
        // 8*(3-b) == {~b, 3'b000} for a two-bit b.
        lwl_sh   = {~byte_addr, 3'b000};
        lwr_sh   = {byte_addr, 3'b000};
        result   = rdata;
        case (op)
            OpLb:    result = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   result = {24'h0, byte_sel};
            OpLh:    result = {{16{half_sel[15]}}, half_sel};
            OpLhu:   result = {16'h0, half_sel};
            OpLwl:   result = (rdata << lwl_sh) | (rt_old & ~(32'hFFFF_FFFF << lwl_sh));
            OpLwr:   result = (rdata >> lwr_sh) | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh));
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: accepts one load, raises an address error for
// misaligned LH/LHU/LW, otherwise issues a word-aligned read on the data
// bus, waits for the response and presents the extracted result.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       cancel in-flight load (bus handshake drains)
//   ld_*                        load offer from the pipeline / ready back
//   data_*                      SRAM-like data bus (req/addr_ok/data_ok)
//   wb_valid, wb_data, wb_dest  one-cycle writeback strobe and payload
//   adel_valid, badvaddr        one-cycle address-error strobe and address
module load_align_unit
    import ld_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        ld_op,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_rt_old,
    input  logic [4:0]        ld_dest,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr,
    output logic [1:0]        data_size,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_dest,
    output logic              adel_valid,
    output logic [ADDR_W-1:0] badvaddr
);

    ld_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] rt_old_q, rt_old_d;
    logic [4:0]        dest_q, dest_d;
    logic              cancel_q, cancel_d;
    logic              data_req_q, data_req_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [1:0]        data_size_q, data_size_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_dest_q, wb_dest_d;
    logic              adel_valid_q, adel_valid_d;
    logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] ext_result;

    load_extractor u_extractor (
        .op        (op_q),
        .byte_addr (off_q),
        .rdata     (data_rdata),
        .rt_old    (rt_old_q),
        .result    (ext_result)
    );

    assign ld_ready = (state_q == StIdle);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rt_old_d     = rt_old_q;
        dest_d       = dest_q;
        cancel_d     = cancel_q;
        data_req_d   = data_req_q;
        data_addr_d  = data_addr_q;
        data_size_d  = data_size_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        wb_dest_d    = wb_dest_q;
        adel_valid_d = 1'b0;
        badvaddr_d   = badvaddr_q;
        capture      = 1'b0;

        accept = ld_valid && ld_ready && !flush;

        case (state_q)
            StIdle: begin
                cancel_d = 1'b0;
                if (accept) begin
                    if (is_misaligned(ld_op, ld_addr[1:0])) begin
                        adel_valid_d = 1'b1;
                        badvaddr_d   = ld_addr;
                    end else begin
                        op_d        = ld_op;
                        off_d       = ld_addr[1:0];
                        rt_old_d    = ld_rt_old;
                        dest_d      = ld_dest;
                        data_req_d  = 1'b1;
                        data_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
                        data_size_d = size_of(ld_op);
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (flush) cancel_d = 1'b1;
                if (data_addr_ok) begin
                    data_req_d = 1'b0;
                    if (data_data_ok) capture = 1'b1;
                    else              state_d = StWait;
                end
            end
            StWait: begin
                if (flush) cancel_d = 1'b1;
                if (data_data_ok) capture = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // A flush arriving with the data still kills the result.
        if (capture) begin
            state_d  = StIdle;
            cancel_d = 1'b0;
            if (!cancel_q && !flush) begin
                wb_valid_d = 1'b1;
                wb_data_d  = ext_result;
                wb_dest_d  = dest_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            off_q        <= '0;
            rt_old_q     <= '0;
            dest_q       <= '0;
            cancel_q     <= 1'b0;
            data_req_q   <= 1'b0;
            data_addr_q  <= '0;
            data_size_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_dest_q    <= '0;
            adel_valid_q <= 1'b0;
            badvaddr_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rt_old_q     <= rt_old_d;
            dest_q       <= dest_d;
            cancel_q     <= cancel_d;
            data_req_q   <= data_req_d;
            data_addr_q  <= data_addr_d;
            data_size_q  <= data_size_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_dest_q    <= wb_dest_d;
            adel_valid_q <= adel_valid_d;
            badvaddr_q   <= badvaddr_d;
        end
    end

    assign data_req   = data_req_q;
    assign data_addr  = data_addr_q;
    assign data_size  = data_size_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_dest    = wb_dest_q;
    assign adel_valid = adel_valid_q;
    assign badvaddr   = badvaddr_q;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Load-side memory unit in the MEM stage, the counterpart of the store byte-lane shifter. It accepts one load from the pipeline and checks alignment. It then issues a word-aligned read on the SRAM-like data bus and waits for the response. Finally it extracts, sign/zero-extends or merges (LWL/LWR) the returned word and presents the result for register writeback. Little-endian byte numbering throughout.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data word width (fixed at 32 for MIPS32; other values unsupported)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
flush  in  1  cancel in-flight load (exception/eret)
ld_valid  in  1  pipeline offers a load
ld_ready  out  1  unit can accept; equals (state==IDLE)
ld_op  in  3  load opcode (ld_pkg encoding: LB, LBU, LH, LHU, LW, LWL, LWR)
ld_addr  in  32  effective byte address
ld_rt_old  in  32  current rt value, used for LWL/LWR merge
ld_dest  in  5  destination register
data_req  out  1  bus request
data_addr  out  32  {addr[31:2],2'b00}
data_size  out  2  0=byte, 1=half, 2=word (LWL/LWR use 2)
data_addr_ok  in  1  bus accepted request
data_data_ok  in  1  read data valid
data_rdata  in  32  read data
wb_valid  out  1  one-cycle result strobe
wb_data  out  32  aligned/extended/merged result
wb_dest  out  5  destination register
adel_valid  out  1  one-cycle address-error-on-load strobe
badvaddr  out  32  faulting address

Behaviour:
- Reset: state=IDLE; data_req, wb_valid, adel_valid = 0; data_addr, data_size, wb_data, wb_dest, badvaddr = 0; cancel flag cleared. Reset mid-transaction abandons the transaction with no drain; the bus is reset with the unit.
- States: IDLE, REQ, WAIT.
- IDLE: accept when ld_valid & ld_ready & !flush. On accept, latch op/addr/rt_old/dest.
- Misalignment at accept: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0. On misalignment: adel_valid=1 and badvaddr=addr next cycle for exactly one cycle. No bus request. Stay IDLE.
- Otherwise, at accept: go to REQ. data_req=1 from the next cycle.
- REQ: data_req, data_addr and data_size are held stable until data_addr_ok. Request is never withdrawn.
  - data_addr_ok, no data_data_ok: go to WAIT.
  - data_addr_ok with data_data_ok in the same cycle: capture data and return to IDLE directly.
- WAIT: on data_data_ok, capture data_rdata. The next cycle: wb_valid=1 for one cycle, with wb_data/wb_dest; state=IDLE.
- ld_ready is 1 during the wb_valid cycle, so back-to-back loads are allowed.
- Minimum latency (addr_ok in the first REQ cycle, data_ok one cycle later): wb_valid 3 cycles after accept.
- Extraction, with b = addr[1:0]:
  - LB/LBU: byte b, sign/zero-extended.
  - LH/LHU: half b[1], sign/zero-extended.
  - LW: whole word.
  - LWL: (rdata << 8*(3-b)) | (rt_old & ~(32'hFFFFFFFF << 8*(3-b))).
  - LWR: (rdata >> 8*b) | (rt_old & ~(32'hFFFFFFFF >> 8*b)).
- Flush:
  - IDLE: flush beats ld_valid; nothing accepted, no adel_valid.
  - REQ/WAIT: set cancel. The bus handshake still completes (drain); returned data is discarded; wb_valid is never raised. ld_ready stays 0 until the drain ends.
  - Same cycle as data_data_ok: the result is suppressed.
  - Cancel clears on return to IDLE.
- wb_valid has no backpressure. The consumer must always take the result.
- data_data_ok while in IDLE or REQ (before addr_ok) is a protocol error and is ignored.

Decomposition:
- Package ld_pkg holds:
  - ld_op encodings: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6.
  - data_size constants.
  - the state enum.
  - an is_misaligned(op, addr) function.
- One combinational sub-module load_extractor(op, byte_addr, rdata, rt_old -> result) holds all lane selection, extension and merge. It is unit-testable alone.

Test Plan:
- LB addr 0x1000_0003, rdata 0x8012_3456 -> data_addr 0x1000_0000, size 0, wb_data 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH addr 0x1000_0002, rdata 0x8001_1234 -> wb_data 0xFFFF_8001. LHU -> 0x0000_8001. LH addr 0x1000_0000 -> 0x0000_1234.
- LW addr 0x1000_0006 -> adel_valid one cycle, badvaddr 0x1000_0006, data_req never asserted, ld_ready stays 1.
- rt_old 0x1122_3344, rdata 0xAABB_CCDD: LWL b=1 -> 0xCCDD_3344; LWR b=2 -> 0x1122_AABB; LWL b=3 and LWR b=0 -> 0xAABB_CCDD.
- LW addr 0x20: addr_ok 3 cycles late, data_ok 2 cycles after that -> data_req/data_addr stable throughout, exactly one wb_valid with the correct data. Then a back-to-back second load is accepted in the wb cycle.
- Flush in WAIT, data_ok 2 cycles later -> no wb_valid, ld_ready returns 1 the cycle after data_ok. Reset asserted in WAIT -> all outputs 0 the next cycle.
